// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operations, next-PC and write-register selects, instruction classes.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_OR  = 3'b011,
        ALU_AND = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JR     = 2'b10,
        PC_JUMP   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        RD_RA = 2'b00,
        RD_RT = 2'b01,
        RD_RD = 2'b10
    } reg_dst_e;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JR,
        CLS_JAL,
        CLS_HALT,
        CLS_UNDEF
    } insn_class_e;

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode decode: instruction class plus the ALU controls
// the control FSM drives during EXE.
module multicycle_decode
    import multicycle_pkg::*;
(
    input  logic [5:0]  opcode,
    output insn_class_e cls,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        ext_sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        cls       = CLS_UNDEF;
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ext_sel   = 1'b1;
        case (opcode)
            OP_ADD:  cls = CLS_RTYPE;
            OP_SUB:  begin cls = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_OR:   begin cls = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_AND:  begin cls = CLS_RTYPE; alu_op = ALU_AND; end
            OP_SLT:  begin cls = CLS_RTYPE; alu_op = ALU_SLT; end
            OP_SLL:  begin cls = CLS_RTYPE; alu_op = ALU_SLL; alu_src_a = 1'b1; end
            OP_ADDI: begin cls = CLS_IMM;   alu_src_b = 1'b1; end
            OP_ORI:  begin
                cls       = CLS_IMM;
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
                ext_sel   = 1'b0;
            end
            OP_LW:   begin cls = CLS_LW;  alu_src_b = 1'b1; end
            OP_SW:   begin cls = CLS_SW;  alu_src_b = 1'b1; end
            OP_BEQ:  begin cls = CLS_BEQ; alu_op = ALU_SUB; end
            OP_J:    cls = CLS_J;
            OP_JR:   cls = CLS_JR;
            OP_JAL:  cls = CLS_JAL;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (IF/ID/EXE/MEM/WB/HALT) driving all datapath enables.
// Define MULTICYCLE_CTRL_INSN_CNT_EN to add the retired-instruction counter insn_cnt.
module multicycle_ctrl
    import multicycle_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic        zero,
    output logic        PCWre,
    output logic [1:0]  PCSrc,
    output logic        IRWre,
    output logic        RegWre,
    output logic [1:0]  RegDst,
    output logic        WrRegDSrc,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic        ExtSel,
    output logic        mRD,
    output logic        mWR,
    output logic        DBDataSrc,
    output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
    ,
    output logic [31:0] insn_cnt
`endif
);

    state_e      state_q;
    insn_class_e cls;
    logic [2:0]  dec_alu_op;
    logic        dec_src_a;
    logic        dec_src_b;
    logic        dec_ext;

    multicycle_decode u_decode (
        .opcode    (opcode),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .alu_src_a (dec_src_a),
        .alu_src_b (dec_src_b),
        .ext_sel   (dec_ext)
    );

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (RST) begin
            state_q <= S_IF;
        end else begin
            case (state_q)
                S_IF:  state_q <= S_ID;
                S_ID:  case (cls)
                    CLS_J, CLS_JR, CLS_JAL, CLS_UNDEF: state_q <= S_IF;
                    CLS_HALT:                          state_q <= S_HALT;
                    default:                           state_q <= S_EXE;
                endcase
                S_EXE: case (cls)
                    CLS_BEQ:        state_q <= S_IF;
                    CLS_LW, CLS_SW: state_q <= S_MEM;
                    default:        state_q <= S_WB;
                endcase
                S_MEM:  state_q <= (cls == CLS_LW) ? S_WB : S_IF;
                S_WB:   state_q <= S_IF;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IF;
            endcase
        end
    end

    // Reset gates every enable so an abandoned instruction cannot write.
    assign state = RST ? S_IF : state_q;

    always_comb begin
        PCWre     = 1'b0;
        PCSrc     = PC_SEQ;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = RD_RA;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        if (!RST) begin
            case (state_q)
                S_IF: IRWre = 1'b1;
                S_ID: case (cls)
                    CLS_J:     begin PCWre = 1'b1; PCSrc = PC_JUMP; end
                    CLS_JR:    begin PCWre = 1'b1; PCSrc = PC_JR;   end
                    CLS_JAL:   begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_JUMP;
                        RegWre    = 1'b1;
                        RegDst    = RD_RA;
                        WrRegDSrc = 1'b0;
                    end
                    CLS_UNDEF: begin PCWre = 1'b1; PCSrc = PC_SEQ; end
                    default: ;
                endcase
                S_EXE: begin
                    ALUOp   = dec_alu_op;
                    ALUSrcA = dec_src_a;
                    ALUSrcB = dec_src_b;
                    ExtSel  = dec_ext;
                    if (cls == CLS_BEQ) begin
                        PCWre = 1'b1;
                        PCSrc = zero ? PC_BRANCH : PC_SEQ;
                    end
                end
                S_MEM: begin
                    if (cls == CLS_LW) begin
                        mRD = 1'b1;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                    end
                end
                S_WB: begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    RegDst    = (cls == CLS_RTYPE) ? RD_RD : RD_RT;
                    DBDataSrc = (cls == CLS_LW);
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            insn_cnt <= '0;
        end else if (PCWre) begin
            insn_cnt <= insn_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;
    import multicycle_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  opcode;
    logic        zero;
    logic        PCWre, IRWre, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB;
    logic        ExtSel, mRD, mWR, DBDataSrc;
    logic [1:0]  PCSrc, RegDst;
    logic [2:0]  ALUOp, state;
`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
    logic [31:0] insn_cnt;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       rgw;
        logic [1:0] rgd;
        logic       wrd;
        logic       sa;
        logic       sb;
        logic [2:0] aop;
        logic       ext;
        logic       mrd;
        logic       mwr;
        logic       dbs;
    } ctl_t;

    typedef struct {
        string       name;
        ctl_t        ctl;
        logic [31:0] cnt;
        bit          cnt_known;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt = '0;
    bit          cnt_known = 1'b0;

    multicycle_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .zero      (zero),
        .PCWre     (PCWre),
        .PCSrc     (PCSrc),
        .IRWre     (IRWre),
        .RegWre    (RegWre),
        .RegDst    (RegDst),
        .WrRegDSrc (WrRegDSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ExtSel    (ExtSel),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .state     (state)
`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
        ,
        .insn_cnt  (insn_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic ctl_t mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                input logic irw, input logic rgw, input logic [1:0] rgd,
                                input logic wrd, input logic sa, input logic sb,
                                input logic [2:0] aop, input logic ext, input logic mrd,
                                input logic mwr, input logic dbs);
        ctl_t c;
        c = '{st, pcw, pcs, irw, rgw, rgd, wrd, sa, sb, aop, ext, mrd, mwr, dbs};
        return c;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a control vector; compare mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            ctl_t act;
            e = sb_q.pop_front();
            act = mk(state, PCWre, PCSrc, IRWre, RegWre, RegDst, WrRegDSrc, ALUSrcA,
                     ALUSrcB, ALUOp, ExtSel, mRD, mWR, DBDataSrc);
            check(e.name, 32'(act), 32'(e.ctl));
`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
            if (e.cnt_known) check({e.name, "/cnt"}, insn_cnt, e.cnt);
`endif
        end
    end

    task automatic step(input logic rst, input logic [5:0] op, input logic zr,
                        input ctl_t exp, input string nm);
        exp_t e;
        RST = rst; opcode = op; zero = zr;
        e.name = nm; e.ctl = exp; e.cnt = exp_cnt; e.cnt_known = cnt_known;
        sb_q.push_back(e);
        if (rst) begin
            exp_cnt = '0;
            cnt_known = 1'b1;
        end else if (exp.pcw) begin
            exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge CLK); #1;
    endtask

    task automatic fetch(input string nm);
        step(1'b0, opcode, zero, mk(S_IF, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             {nm, "/IF"});
    endtask

    task automatic idle_id(input string nm, input logic [5:0] op, input logic zr);
        step(1'b0, op, zr, mk(S_ID, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             {nm, "/ID"});
    endtask

    task automatic do_rtype(input string nm, input logic [5:0] op, input logic [2:0] aop,
                            input logic sa);
        fetch(nm);
        idle_id(nm, op, 1'b0);
        step(1'b0, op, 1'b0, mk(S_EXE, 0, 2'b00, 0, 0, 2'b00, 0, sa, 0, aop, 1, 0, 0, 0),
             {nm, "/EXE"});
        step(1'b0, op, 1'b0, mk(S_WB, 1, 2'b00, 0, 1, 2'b10, 1, 0, 0, 3'b000, 0, 0, 0, 0),
             {nm, "/WB"});
    endtask

    task automatic do_imm(input string nm, input logic [5:0] op, input logic [2:0] aop,
                          input logic ext);
        fetch(nm);
        idle_id(nm, op, 1'b0);
        step(1'b0, op, 1'b0, mk(S_EXE, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, aop, ext, 0, 0, 0),
             {nm, "/EXE"});
        step(1'b0, op, 1'b0, mk(S_WB, 1, 2'b00, 0, 1, 2'b01, 1, 0, 0, 3'b000, 0, 0, 0, 0),
             {nm, "/WB"});
    endtask

    task automatic do_lw();
        fetch("lw");
        idle_id("lw", OP_LW, 1'b0);
        step(1'b0, OP_LW, 1'b0, mk(S_EXE, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 0, 0),
             "lw/EXE");
        step(1'b0, OP_LW, 1'b0, mk(S_MEM, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 1, 0, 0),
             "lw/MEM");
        step(1'b0, OP_LW, 1'b0, mk(S_WB, 1, 2'b00, 0, 1, 2'b01, 1, 0, 0, 3'b000, 0, 0, 0, 1),
             "lw/WB");
    endtask

    task automatic do_sw(input bit rst_in_mem);
        fetch("sw");
        idle_id("sw", OP_SW, 1'b0);
        step(1'b0, OP_SW, 1'b0, mk(S_EXE, 0, 2'b00, 0, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 0, 0),
             "sw/EXE");
        if (rst_in_mem)
            step(1'b1, OP_SW, 1'b0, mk(S_IF, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
                 "sw/MEM_rst");
        else
            step(1'b0, OP_SW, 1'b0, mk(S_MEM, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 1, 0),
                 "sw/MEM");
    endtask

    task automatic do_beq(input logic zr);
        string nm;
        nm = zr ? "beq_taken" : "beq_not";
        fetch(nm);
        idle_id(nm, OP_BEQ, zr);
        step(1'b0, OP_BEQ, zr, mk(S_EXE, 1, zr ? 2'b01 : 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b001,
             1, 0, 0, 0), {nm, "/EXE"});
    endtask

    task automatic do_jump(input string nm, input logic [5:0] op, input logic [1:0] pcs,
                           input logic link);
        fetch(nm);
        step(1'b0, op, 1'b0, mk(S_ID, 1, pcs, 0, link, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             {nm, "/ID"});
    endtask

    initial begin
        RST = 1'b1; opcode = 6'b000000; zero = 1'b0;
        @(posedge CLK); #1;
        step(1'b1, 6'b000000, 1'b0, mk(S_IF, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             "reset0");
        step(1'b1, 6'b000000, 1'b0, mk(S_IF, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             "reset1");

        do_lw();
        do_beq(1'b1);
        do_beq(1'b0);
        do_rtype("add", OP_ADD, 3'b000, 1'b0);
        do_rtype("sub", OP_SUB, 3'b001, 1'b0);
        do_rtype("or",  OP_OR,  3'b011, 1'b0);
        do_rtype("and", OP_AND, 3'b100, 1'b0);
        do_rtype("sll", OP_SLL, 3'b010, 1'b1);
        do_rtype("slt", OP_SLT, 3'b101, 1'b0);
        do_imm("addi", OP_ADDI, 3'b000, 1'b1);
        do_imm("ori",  OP_ORI,  3'b011, 1'b0);
        do_sw(1'b0);
        do_jump("j",     OP_J,      2'b11, 1'b0);
        do_jump("jr",    OP_JR,     2'b10, 1'b0);
        do_jump("undef", 6'b000011, 2'b00, 1'b0);
        do_jump("jal",   OP_JAL,    2'b11, 1'b1);

        fetch("halt");
        idle_id("halt", OP_HALT, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, OP_HALT, 1'b0, mk(S_HALT, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
                 $sformatf("halt/HOLD%0d", i));
        step(1'b1, OP_HALT, 1'b0, mk(S_IF, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 0, 0),
             "halt/RST");

        do_sw(1'b1);
        do_rtype("add2", OP_ADD, 3'b000, 1'b0);
        do_sw(1'b0);
        do_jump("j2", OP_J, 2'b11, 1'b0);
        fetch("final");

`ifdef MULTICYCLE_CTRL_INSN_CNT_EN
        check("insn_cnt_after_add_sw_j", insn_cnt, 32'd3);
`endif

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge CLK);
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
